// File: rtl/dmem_ctrl_if.sv
// Memory-side bus of the data-memory controller: a req/ack handshake with
// word address, byte enables and lane-replicated write data.
interface dmem_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access controller behind the single-cycle MIPS datapath: lane steering,
// load extension and req/ack sequencing. Optional macro DMEM_ALIGN_CHECK_EN faults misaligned accesses.
module dmem_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        err,
  dmem_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt_p0;
  logic        req_p0, we_p0, err_p0;
  logic [31:0] addr_p0, wdata_p0, rdata_p0;
  logic [3:0]  be_p0;
  logic [1:0]  size_p0, lane_p0;
  logic        sign_p0;
  logic        req_seen, misalign, capture, ack_ok, timeout;

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] steer_wdata(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] sz, input logic sx,
                                              input logic [1:0] lo, input logic [31:0] rd);
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    b8  = rd[{lo, 3'b000} +: 8];
    h16 = lo[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'b00:   return sx ? 32'(b8)  : {24'd0, b8};
      2'b01:   return sx ? 32'(h16) : {16'd0, h16};
      default: return rd;
    endcase
  endfunction

  assign req_seen = memread | memwrite;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = ((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    ack_ok    = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (req_seen) begin
          capture   = 1'b1;
          state_nxt = misalign ? DONE : REQ;
        end
      end
      REQ: begin
        // Ack on the final allowed cycle still wins over the timeout.
        if (bus.bus_ack) begin
          ack_ok    = 1'b1;
          state_nxt = DONE;
        end else if (cnt_p0 >= 8'(TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, bus handshake and result latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p0   <= '0;
      req_p0   <= 1'b0;
      we_p0    <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      be_p0    <= '0;
      size_p0  <= '0;
      lane_p0  <= '0;
      sign_p0  <= 1'b0;
      rdata_p0 <= '0;
      err_p0   <= 1'b0;
    end else begin
      if (capture) begin
        cnt_p0   <= '0;
        req_p0   <= ~misalign;
        we_p0    <= memwrite;
        addr_p0  <= {addr[31:2], 2'b00};
        wdata_p0 <= steer_wdata(size, wdata);
        be_p0    <= lane_be(size, addr[1:0]);
        size_p0  <= size;
        lane_p0  <= addr[1:0];
        sign_p0  <= sign_ext;
        if (misalign) begin
          err_p0   <= 1'b1;
          rdata_p0 <= '0;
        end
      end
      if (state == REQ) begin
        if (ack_ok) begin
          req_p0 <= 1'b0;
          err_p0 <= 1'b0;
          if (!we_p0) rdata_p0 <= load_extend(size_p0, sign_p0, lane_p0, bus.bus_rdata);
        end else if (timeout) begin
          req_p0   <= 1'b0;
          err_p0   <= 1'b1;
          rdata_p0 <= '0;
        end else begin
          cnt_p0 <= cnt_p0 + 8'd1;
        end
      end
      if (state == DONE) err_p0 <= 1'b0;
    end
  end

  assign stall         = rst & (((state == IDLE) & req_seen) | (state == REQ));
  assign readdata      = rdata_p0;
  assign err           = err_p0;
  assign bus.bus_req   = req_p0;
  assign bus.bus_we    = we_p0;
  assign bus.bus_addr  = addr_p0;
  assign bus.bus_wdata = wdata_p0;
  assign bus.bus_be    = be_p0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed and randomized accesses against a byte-lane reference model.
module tb_dmem_ctrl;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread, memwrite, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata, readdata;
  logic        stall, err;
  logic [31:0] model_rd;
  int          checks = 0;
  int          errors = 0;

  dmem_ctrl_if bus_if();

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .memread  (memread),
    .memwrite (memwrite),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .readdata (readdata),
    .stall    (stall),
    .err      (err),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // One complete access; the bench plays the memory, acking after 'waits' idle REQ cycles.
  task automatic access(input bit wr, input logic [1:0] sz, input bit sx, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits);
    int          n, lane, nstall, nreq, exp_nreq;
    bit          mis, acked, done;
    logic [31:0] exp_wd, mask, val;
    logic [3:0]  exp_be;
    n    = nbytes(sz);
    lane = int'(a[1:0]) / n * n;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (int'(a[1:0]) % n) != 0;
`else
    mis = 1'b0;
`endif
    acked    = !mis && (waits < TO);
    exp_nreq = mis ? 0 : (acked ? waits + 1 : TO);
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
    exp_be = 4'(((1 << n) - 1) << lane);
    mask   = (n == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * n)) - 1);
    val    = (rd >> (8 * lane)) & mask;
    if (sx && n < 4 && val[8*n-1]) val = val | ~mask;
    if (!acked)   model_rd = 32'd0;
    else if (!wr) model_rd = val;

    nstall = 0;
    nreq   = 0;
    done   = 1'b0;
    @(negedge clk);
    memwrite = wr;
    memread  = ~wr;
    size     = sz;
    sign_ext = sx;
    addr     = a;
    wdata    = wd;
    bus_if.bus_ack   = 1'($urandom_range(0, 1));
    bus_if.bus_rdata = $urandom;
    for (int cyc = 0; cyc < TO + 8 && !done; cyc++) begin
      #1;
      if (!stall) begin
        done = 1'b1;
      end else begin
        nstall++;
        if (bus_if.bus_req) begin
          check("bus_we",    32'(bus_if.bus_we), 32'(wr));
          check("bus_addr",  bus_if.bus_addr,    a & 32'hFFFF_FFFC);
          check("bus_be",    32'(bus_if.bus_be), 32'(exp_be));
          if (wr) check("bus_wdata", bus_if.bus_wdata, exp_wd);
          bus_if.bus_ack   = (nreq == waits);
          bus_if.bus_rdata = bus_if.bus_ack ? rd : $urandom;
          nreq++;
        end
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
      end
    end
    check("no_hang",       32'(done),           32'd1);
    check("stall_cycles",  32'(nstall),         32'(1 + exp_nreq));
    check("req_cycles",    32'(nreq),           32'(exp_nreq));
    check("done_err",      32'(err),            32'(!acked));
    check("done_readdata", readdata,            model_rd);
    check("done_bus_req",  32'(bus_if.bus_req), 32'd0);
    @(negedge clk);
    memread  = 1'b0;
    memwrite = 1'b0;
    #1;
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_err",   32'(err),   32'd0);
  endtask

  initial begin
    int w;
    rst      = 1'b0;
    memread  = 1'b1;
    memwrite = 1'b0;
    size     = 2'b10;
    sign_ext = 1'b0;
    addr     = 32'h0000_0040;
    wdata    = 32'h0;
    model_rd = 32'h0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall",     32'(stall),             32'd0);
    check("rst_readdata",  readdata,               32'd0);
    check("rst_err",       32'(err),               32'd0);
    check("rst_bus_req",   32'(bus_if.bus_req),    32'd0);
    check("rst_bus_we",    32'(bus_if.bus_we),     32'd0);
    check("rst_bus_addr",  bus_if.bus_addr,        32'd0);
    check("rst_bus_wdata", bus_if.bus_wdata,       32'd0);
    check("rst_bus_be",    32'(bus_if.bus_be),     32'd0);
    memread = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    access(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);
    access(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A5, 32'h0, 1);
    check("store_byte_wdata", bus_if.bus_wdata, 32'hA5A5_A5A5);
    check("store_byte_be",    32'(bus_if.bus_be), 32'h8);
    access(1'b0, 2'b00, 1'b1, 32'h0000_0213, 32'h0, 32'h80FF_0000, 0);
    check("lb_signed", readdata, 32'hFFFF_FF80);
    access(1'b0, 2'b00, 1'b0, 32'h0000_0213, 32'h0, 32'h80FF_0000, 2);
    check("lb_unsigned", readdata, 32'h0000_0080);
    access(1'b1, 2'b01, 1'b0, 32'h0000_0300, 32'h0000_5678, 32'h0, 0);
    check("store_keeps_readdata", readdata, 32'h0000_0080);
    access(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 32'h1234_ABCD, 4);
    check("lh_upper", readdata, 32'h0000_1234);
    access(1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0, 32'h1234_ABCD, 0);
    check("lh_lower_signed", readdata, 32'hFFFF_ABCD);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 100);
    check("timeout_readdata", readdata, 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0404, 32'h0, 32'h0BAD_CAFE, TO - 1);
    access(1'b0, 2'b11, 1'b0, 32'h0000_0101, 32'h0, 32'h1122_3344, 0);
    access(1'b0, 2'b01, 1'b0, 32'h0000_0105, 32'h0, 32'h1122_3344, 0);

    // Reset while a load is waiting for ack.
    @(negedge clk);
    memread  = 1'b1;
    memwrite = 1'b0;
    size     = 2'b10;
    addr     = 32'h0000_0300;
    repeat (2) @(negedge clk);
    #1;
    check("mid_req_up", 32'(bus_if.bus_req), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_bus_req",  32'(bus_if.bus_req), 32'd0);
    check("mid_rst_stall",    32'(stall),          32'd0);
    check("mid_rst_readdata", readdata,            32'd0);
    model_rd = 32'd0;
    @(negedge clk);
    memread = 1'b0;
    rst     = 1'b1;
    #1;
    check("post_rst_stall", 32'(stall), 32'd0);
    access(1'b0, 2'b00, 1'b1, 32'h0000_0311, 32'h0, 32'h0000_7F00, 1);

    for (int t = 0; t < 60; t++) begin
      w = ($urandom_range(0, 9) == 0) ? TO + 3 : int'($urandom_range(0, 5));
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller that sits directly downstream of the single-cycle MIPS datapath. It takes the datapath's ALU result as address, the store data and the load/store controls, and runs a req/ack transaction on a variable-latency memory bus. It performs byte/halfword lane steering and load extension, and holds the datapath with `stall` until the access completes.

## Interface
- `TIMEOUT`, default 15: maximum cycles spent in REQ before the access is abandoned (valid range 1–255).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `memread` in 1: load request from control.
- `memwrite` in 1: store request from control.
- `size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `sign_ext` in 1: sign-extend byte/half loads when 1, zero-extend when 0.
- `addr` in 32: byte address (datapath `aluout`).
- `wdata` in 32: store data (datapath `writedata`).
- `readdata` out 32: extended load result to the datapath result mux.
- `stall` out 1: combinational; holds PC and register writes while high.
- `err` out 1: access fault (timeout or misalignment); valid in DONE only.
- `bus_req` out 1: registered request, held until ack.
- `bus_we` out 1: write strobe.
- `bus_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_be` out 4: byte enables, bit k = byte lane k (little-endian).
- `bus_ack` in 1: access complete; `bus_rdata` is valid in the same cycle.
- `bus_rdata` in 32: read data.

## Operation
- FSM has three states: IDLE, REQ, DONE.
- **IDLE:**
  - If `memread|memwrite`, capture address, size, sign and data, then go to REQ.
  - `memwrite` has priority when both request lines are high.
- **REQ:**
  - `bus_req`=1; bus fields are stable until ack.
  - On `bus_ack`, latch `bus_rdata` (lane extraction and extension applied), `err`=0, and go to DONE.
  - If the counter reaches `TIMEOUT` without ack: `bus_req` drops, `readdata`=0, `err`=1, go to DONE.
- **DONE:** `stall`=0 for one cycle so the datapath retires the instruction, then go to IDLE. Request lines seen in DONE belong to the retiring instruction and are ignored.
- `stall` = (IDLE & (`memread|memwrite`)) | REQ.
- **Byte access:** `bus_be` = 1<<`addr[1:0]`; `bus_wdata` = `{4{wdata[7:0]}}`; load takes lane `addr[1:0]`.
- **Half access:** `bus_be` = 0011 (`addr[1]`=0) or 1100 (`addr[1]`=1); `bus_wdata` = `{2{wdata[15:0]}}`.
- **Word access:** `bus_be`=1111.
- On stores, `readdata` holds its previous value.

## Timing
- **Reset values:**
  - State IDLE, timeout counter 0.
  - `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`, `readdata`, `err` all 0.
  - `stall` is forced to 0 while `rst`=0.
- **Minimum access time** is 3 cycles:
  - C0: IDLE, request seen, `stall`=1.
  - C1: REQ with `bus_req`=1; `bus_ack` arrives.
  - C2: DONE, `stall`=0, `readdata` valid.
- Each extra wait cycle before ack adds one cycle.
- `bus_ack` is honoured only in REQ; ack in any other state is ignored.
- The timeout counter is cleared on entry to REQ and increments each REQ cycle without ack. Ack in the same cycle the counter reaches `TIMEOUT` counts as success.
- **Reset mid-transaction:** `bus_req` drops asynchronously and the FSM returns to IDLE. No partial result is reported.

## Configuration
- With `DMEM_ALIGN_CHECK_EN` defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, issues no bus transaction.
  - The FSM goes IDLE→DONE directly (2-cycle access) with `err`=1 and `readdata`=0.
- Without the macro: no check. Word accesses ignore `addr[1:0]`, and half accesses ignore `addr[0]`.

## Test plan
- Store word: `addr`=0x100, `wdata`=0xDEADBEEF, ack in first REQ cycle → `bus_addr`=0x100, `bus_be`=1111, `bus_we`=1, `stall` high exactly 2 cycles.
- Store byte: `addr`=0x103, `wdata`=0x000000A5 → `bus_be`=1000, `bus_wdata`=0xA5A5A5A5.
- Load byte: `bus_rdata`=0x80FF0000, `addr[1:0]`=3 → `readdata`=0xFFFFFF80 with `sign_ext`=1, and 0x00000080 with `sign_ext`=0.
- Load half: `addr`=0x202, ack after 4 wait cycles, `bus_rdata`=0x1234ABCD → `readdata`=0x00001234 with `sign_ext`=1, and `stall` high 6 cycles.
- Timeout: `TIMEOUT`=15, no ack → `bus_req` drops after 15 REQ cycles, DONE with `err`=1, `readdata`=0; assert `rst` during REQ → `bus_req`=0 immediately.
- Misaligned word load at 0x101:
  - With `DMEM_ALIGN_CHECK_EN`: `bus_req` never rises, `err`=1.
  - Without it: `bus_addr`=0x100, `err`=0.
